// File: rtl/nmea_pkg.sv
// Shared types and constants for the NMEA RMC sentence sequencer.
// States, character codes, default field indices and hex-digit decoding.
package nmea_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    FIELD = 2'd1,
    CKSUM = 2'd2
  } state_e;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_R      = 8'h52;
  localparam logic [7:0] CH_M      = 8'h4D;
  localparam logic [7:0] CH_C      = 8'h43;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;

  localparam int DEF_MAX_FIELDS   = 13;
  localparam int DEF_TIME_FIELD   = 1;
  localparam int DEF_STATUS_FIELD = 2;
  localparam int DEF_DATE_FIELD   = 9;

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/nmea_cksum.sv
// NMEA checksum engine: running XOR of sentence bytes and the trailing
// two-character hex compare. Match/error flags are valid in the byte cycle.
module nmea_cksum
  import nmea_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       vld_i,
  input  logic       acc_en_i,
  input  logic       chk_en_i,
  output logic       match_o,
  output logic       err_o
);

  logic [7:0] acc_q;
  logic [3:0] hi_q;
  logic       have_hi_q;
  logic [4:0] nib;

  always_comb begin
    nib     = hex2nib(data_i);
    match_o = 1'b0;
    err_o   = 1'b0;
    if (vld_i && chk_en_i) begin
      if (!nib[4])                          err_o   = 1'b1;
      else if (have_hi_q) begin
        if ({hi_q, nib[3:0]} == acc_q)      match_o = 1'b1;
        else                                err_o   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= 8'd0;
      hi_q      <= 4'd0;
      have_hi_q <= 1'b0;
    end else if (vld_i) begin
      // A '$' anywhere starts a fresh sentence, including one that aborts another.
      if (data_i == CH_DOLLAR)                      acc_q <= 8'd0;
      else if (acc_en_i && data_i != CH_STAR)       acc_q <= acc_q ^ data_i;
      if (chk_en_i && nib[4] && !have_hi_q) begin
        hi_q      <= nib[3:0];
        have_hi_q <= 1'b1;
      end else begin
        have_hi_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nmea_rmc_ctrl.sv
// RMC sentence sequencer: streams fields into text RAM rows, commits time/date.
// Define NMEA_CKSUM_EN to verify the trailing *hh checksum before committing.
module nmea_rmc_ctrl
  import nmea_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int ROW_SHIFT    = 5,
  parameter int MAX_FIELDS   = DEF_MAX_FIELDS,
  parameter int TIME_FIELD   = DEF_TIME_FIELD,
  parameter int STATUS_FIELD = DEF_STATUS_FIELD,
  parameter int DATE_FIELD   = DEF_DATE_FIELD
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [23:0]       time_bcd,
  output logic [23:0]       date_bcd,
  output logic              time_valid,
  output logic              fix_active,
  output logic              busy,
  output logic              frame_done,
  output logic              cksum_err
);

  localparam int FW      = $clog2(MAX_FIELDS + 2);
  localparam int CW      = ROW_SHIFT + 1;
  localparam int ROW_LEN = 1 << ROW_SHIFT;

  state_e            state_q, state_d;
  logic [23:0]       hist_q, hist_d;
  logic [FW-1:0]     field_q, field_d;
  logic [CW-1:0]     col_q, col_d;
  logic [23:0]       tdig_q, tdig_d, ddig_q, ddig_d;
  logic              tbad_q, tbad_d, dbad_q, dbad_d;
  logic              tfull_q, tfull_d, dfull_q, dfull_d;
  logic              fixsh_q, fixsh_d;

  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [23:0]       time_q, time_d, date_q, date_d;
  logic              tvalid_q, tvalid_d, fix_q, fix_d;
  logic              busy_q, busy_d, done_q, done_d, cerr_q, cerr_d;

  logic              do_commit;
  logic              is_digit;
  logic [ADDR_W-1:0] wr_addr;

`ifdef NMEA_CKSUM_EN
  logic ck_match, ck_err;

  nmea_cksum u_cksum (
    .clk_i   (PixelClk),
    .rst_ni  (nRST),
    .data_i  (rx_data),
    .vld_i   (rx_valid),
    .acc_en_i(state_q != CKSUM),
    .chk_en_i(state_q == CKSUM),
    .match_o (ck_match),
    .err_o   (ck_err)
  );
`endif

  assign is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
  assign wr_addr  = (ADDR_W'(field_q - FW'(1)) << ROW_SHIFT) | ADDR_W'(col_q[ROW_SHIFT-1:0]);

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    field_d   = field_q;
    col_d     = col_q;
    tdig_d    = tdig_q;
    ddig_d    = ddig_q;
    tbad_d    = tbad_q;
    dbad_d    = dbad_q;
    tfull_d   = tfull_q;
    dfull_d   = dfull_q;
    fixsh_d   = fixsh_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    time_d    = time_q;
    date_d    = date_q;
    tvalid_d  = tvalid_q;
    fix_d     = fix_q;
    done_d    = 1'b0;
    cerr_d    = 1'b0;
    do_commit = 1'b0;

    if (rx_valid) begin
      hist_d = {hist_q[15:0], rx_data};
      case (state_q)
        HUNT: begin
          if (rx_data == CH_COMMA && hist_q == {CH_R, CH_M, CH_C}) begin
            state_d = FIELD;
            field_d = FW'(1);
            col_d   = '0;
            tdig_d  = '0;
            ddig_d  = '0;
            tbad_d  = 1'b0;
            dbad_d  = 1'b0;
            tfull_d = 1'b0;
            dfull_d = 1'b0;
            fixsh_d = 1'b0;
          end
        end
        FIELD: begin
          if (rx_data == CH_STAR) begin
`ifdef NMEA_CKSUM_EN
            state_d   = CKSUM;
`else
            state_d   = HUNT;
            do_commit = 1'b1;
`endif
          end else if (rx_data == CH_DOLLAR) begin
            state_d = HUNT;
          end else if (rx_data == CH_COMMA) begin
            if (field_q <= FW'(MAX_FIELDS)) field_d = field_q + FW'(1);
            col_d = '0;
          end else if (field_q <= FW'(MAX_FIELDS) && col_q < CW'(ROW_LEN)) begin
            we_d    = 1'b1;
            waddr_d = wr_addr;
            wdata_d = rx_data;
            col_d   = col_q + CW'(1);
            // Digit slots 0..5 map to BCD nibbles, slot 0 in the top nibble.
            for (int k = 0; k < 6; k++) begin
              if (col_q == CW'(k)) begin
                if (field_q == FW'(TIME_FIELD)) begin
                  tdig_d[(5-k)*4 +: 4] = rx_data[3:0];
                  if (!is_digit) tbad_d = 1'b1;
                  if (k == 5) tfull_d = 1'b1;
                end
                if (field_q == FW'(DATE_FIELD)) begin
                  ddig_d[(5-k)*4 +: 4] = rx_data[3:0];
                  if (!is_digit) dbad_d = 1'b1;
                  if (k == 5) dfull_d = 1'b1;
                end
              end
            end
            if (field_q == FW'(STATUS_FIELD) && col_q == '0 && rx_data == CH_A)
              fixsh_d = 1'b1;
          end
        end
        CKSUM: begin
`ifdef NMEA_CKSUM_EN
          if (ck_err) begin
            cerr_d  = 1'b1;
            state_d = HUNT;
          end else if (ck_match) begin
            do_commit = 1'b1;
            state_d   = HUNT;
          end
`else
          state_d = HUNT;
`endif
        end
        default: state_d = HUNT;
      endcase
    end

    if (do_commit) begin
      done_d = 1'b1;
      fix_d  = fixsh_q;
      if (tfull_q && !tbad_q) begin
        time_d   = tdig_q;
        tvalid_d = 1'b1;
      end
      if (dfull_q && !dbad_q) date_d = ddig_q;
    end

    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= HUNT;
      hist_q   <= '0;
      field_q  <= '0;
      col_q    <= '0;
      tdig_q   <= '0;
      ddig_q   <= '0;
      tbad_q   <= 1'b0;
      dbad_q   <= 1'b0;
      tfull_q  <= 1'b0;
      dfull_q  <= 1'b0;
      fixsh_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      time_q   <= '0;
      date_q   <= '0;
      tvalid_q <= 1'b0;
      fix_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      field_q  <= field_d;
      col_q    <= col_d;
      tdig_q   <= tdig_d;
      ddig_q   <= ddig_d;
      tbad_q   <= tbad_d;
      dbad_q   <= dbad_d;
      tfull_q  <= tfull_d;
      dfull_q  <= dfull_d;
      fixsh_q  <= fixsh_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      time_q   <= time_d;
      date_q   <= date_d;
      tvalid_q <= tvalid_d;
      fix_q    <= fix_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cerr_q   <= cerr_d;
    end
  end

  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign ram_we     = we_q;
  assign time_bcd   = time_q;
  assign date_bcd   = date_q;
  assign time_valid = tvalid_q;
  assign fix_active = fix_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign cksum_err  = cerr_q;

endmodule

// File: tb/tb_nmea_rmc_ctrl.sv
// Directed bench for nmea_rmc_ctrl: feeds NMEA sentences and checks RAM
// writes and committed time/date/fix against hand-computed values.
module tb_nmea_rmc_ctrl;

  logic        PixelClk = 1'b0;
  logic        nRST     = 1'b1;
  logic [7:0]  rx_data  = 8'd0;
  logic        rx_valid = 1'b0;
  logic [9:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [23:0] time_bcd, date_bcd;
  logic        time_valid, fix_active, busy, frame_done, cksum_err;

  nmea_rmc_ctrl dut (
    .PixelClk  (PixelClk),
    .nRST      (nRST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .time_bcd  (time_bcd),
    .date_bcd  (date_bcd),
    .time_valid(time_valid),
    .fix_active(fix_active),
    .busy      (busy),
    .frame_done(frame_done),
    .cksum_err (cksum_err)
  );

  always #5 PixelClk = ~PixelClk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:1023];
  int         wep [0:1023];
  int         epoch  = 0;
  int         wr_tot = 0, fd_tot = 0, ce_tot = 0, busy_tot = 0;
  int         wr_b, fd_b, ce_b, busy_b;
  logic [23:0] exp_time, exp_date;

  always @(negedge PixelClk) begin
    if (nRST) begin
      if (ram_we) begin
        mem[ram_waddr] = ram_wdata;
        wep[ram_waddr] = epoch;
        wr_tot++;
      end
      if (frame_done) fd_tot++;
      if (cksum_err)  ce_tot++;
      if (busy)       busy_tot++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  function automatic logic [7:0] hexch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  function automatic string rmc(input string t, input string st, input string d);
    return {"GPRMC,", t, ",", st, ",,,", ",,,", ",", d, ",,"};
  endfunction

  task automatic begin_epoch();
    epoch++;
    wr_b = wr_tot; fd_b = fd_tot; ce_b = ce_tot; busy_b = busy_tot;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge PixelClk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge PixelClk);
    rx_valid = 1'b0;
  endtask

  task automatic send_raw(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  task automatic send_sentence(input string body, input bit corrupt);
    logic [7:0] x;
    x = 8'd0;
    send_byte(8'h24);
    for (int i = 0; i < body.len(); i++) begin
      x = x ^ 8'(body[i]);
      send_byte(8'(body[i]));
    end
    if (corrupt) x = x ^ 8'h01;
    send_byte(8'h2A);
    send_byte(hexch(x[7:4]));
    send_byte(hexch(x[3:0]));
    repeat (3) @(negedge PixelClk);
  endtask

  task automatic check_row(input string name, input int base, input string s);
    for (int i = 0; i < s.len(); i++) begin
      n_vec++;
      if (mem[base+i] !== 8'(s[i]) || wep[base+i] != epoch) begin
        n_err++;
        $display("FAIL %s addr %0d: got %h (epoch %0d) want %h (epoch %0d)",
                 name, base+i, mem[base+i], wep[base+i], 8'(s[i]), epoch);
      end
    end
  endtask

  task automatic test_reset();
    #3 nRST = 1'b0;
    repeat (2) @(negedge PixelClk);
    n_vec++; if (ram_we !== 1'b0)      begin n_err++; $display("FAIL rst ram_we got %b want 0", ram_we); end
    n_vec++; if (ram_waddr !== 10'd0)  begin n_err++; $display("FAIL rst ram_waddr got %h want 0", ram_waddr); end
    n_vec++; if (ram_wdata !== 8'd0)   begin n_err++; $display("FAIL rst ram_wdata got %h want 0", ram_wdata); end
    n_vec++; if (time_bcd !== 24'd0)   begin n_err++; $display("FAIL rst time_bcd got %h want 0", time_bcd); end
    n_vec++; if (date_bcd !== 24'd0)   begin n_err++; $display("FAIL rst date_bcd got %h want 0", date_bcd); end
    n_vec++; if (time_valid !== 1'b0)  begin n_err++; $display("FAIL rst time_valid got %b want 0", time_valid); end
    n_vec++; if (fix_active !== 1'b0)  begin n_err++; $display("FAIL rst fix_active got %b want 0", fix_active); end
    n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL rst busy got %b want 0", busy); end
    n_vec++; if (frame_done !== 1'b0)  begin n_err++; $display("FAIL rst frame_done got %b want 0", frame_done); end
    n_vec++; if (cksum_err !== 1'b0)   begin n_err++; $display("FAIL rst cksum_err got %b want 0", cksum_err); end
    nRST = 1'b1;
    repeat (2) @(negedge PixelClk);
  endtask

  task automatic test_rmc_basic();
    begin_epoch();
    send_sentence("GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 1'b0);
    n_vec++; if (time_bcd !== 24'h123519) begin n_err++; $display("FAIL basic time_bcd got %h want 123519", time_bcd); end
    n_vec++; if (date_bcd !== 24'h230394) begin n_err++; $display("FAIL basic date_bcd got %h want 230394", date_bcd); end
    n_vec++; if (fix_active !== 1'b1)     begin n_err++; $display("FAIL basic fix_active got %b want 1", fix_active); end
    n_vec++; if (time_valid !== 1'b1)     begin n_err++; $display("FAIL basic time_valid got %b want 1", time_valid); end
    n_vec++; if (fd_tot - fd_b != 1)      begin n_err++; $display("FAIL basic frame_done pulses got %0d want 1", fd_tot - fd_b); end
    n_vec++; if (ce_tot - ce_b != 0)      begin n_err++; $display("FAIL basic cksum_err pulses got %0d want 0", ce_tot - ce_b); end
    n_vec++; if (wr_tot - wr_b != 48)     begin n_err++; $display("FAIL basic write count got %0d want 48", wr_tot - wr_b); end
    n_vec++; if (busy_tot - busy_b == 0)  begin n_err++; $display("FAIL basic busy cycles got 0 want nonzero"); end
    n_vec++; if (busy !== 1'b0)           begin n_err++; $display("FAIL basic busy after got %b want 0", busy); end
    check_row("basic time row", 0, "123519");
    check_row("basic status row", 32, "A");
    check_row("basic date row", 256, "230394");
    exp_time = 24'h123519;
    exp_date = 24'h230394;
  endtask

  task automatic test_bad_cksum();
    begin_epoch();
    send_sentence(rmc("010203", "A", "010199"), 1'b1);
`ifdef NMEA_CKSUM_EN
    n_vec++; if (ce_tot - ce_b != 1) begin n_err++; $display("FAIL badck cksum_err pulses got %0d want 1", ce_tot - ce_b); end
    n_vec++; if (fd_tot - fd_b != 0) begin n_err++; $display("FAIL badck frame_done pulses got %0d want 0", fd_tot - fd_b); end
`else
    n_vec++; if (ce_tot - ce_b != 0) begin n_err++; $display("FAIL badck cksum_err pulses got %0d want 0", ce_tot - ce_b); end
    n_vec++; if (fd_tot - fd_b != 1) begin n_err++; $display("FAIL badck frame_done pulses got %0d want 1", fd_tot - fd_b); end
    exp_time = 24'h010203;
    exp_date = 24'h010199;
`endif
    n_vec++; if (time_bcd !== exp_time) begin n_err++; $display("FAIL badck time_bcd got %h want %h", time_bcd, exp_time); end
    n_vec++; if (date_bcd !== exp_date) begin n_err++; $display("FAIL badck date_bcd got %h want %h", date_bcd, exp_date); end
    check_row("badck time row", 0, "010203");
    check_row("badck date row", 256, "010199");
  endtask

  task automatic test_void_bad_time();
    begin_epoch();
    send_sentence(rmc("12a519", "V", "150607"), 1'b0);
    exp_date = 24'h150607;
    n_vec++; if (fd_tot - fd_b != 1)    begin n_err++; $display("FAIL void frame_done pulses got %0d want 1", fd_tot - fd_b); end
    n_vec++; if (fix_active !== 1'b0)   begin n_err++; $display("FAIL void fix_active got %b want 0", fix_active); end
    n_vec++; if (time_bcd !== exp_time) begin n_err++; $display("FAIL void time_bcd got %h want %h", time_bcd, exp_time); end
    n_vec++; if (date_bcd !== exp_date) begin n_err++; $display("FAIL void date_bcd got %h want %h", date_bcd, exp_date); end
    n_vec++; if (time_valid !== 1'b1)   begin n_err++; $display("FAIL void time_valid got %b want 1", time_valid); end
    check_row("void time row", 0, "12a519");
    check_row("void status row", 32, "V");
  endtask

  task automatic test_long_field();
    string long40;
    long40 = {"0123456789", "0123456789", "0123456789", "0123456789"};
    begin_epoch();
    send_sentence({"GPRMC,1,A,", long40, ",N,"}, 1'b0);
    check_row("long row2", 64, long40.substr(0, 31));
    check_row("long field4", 96, "N");
    n_vec++; if (wep[97] == epoch)        begin n_err++; $display("FAIL long addr97 written got 1 want 0"); end
    n_vec++; if (wr_tot - wr_b != 35)     begin n_err++; $display("FAIL long write count got %0d want 35", wr_tot - wr_b); end
    n_vec++; if (time_bcd !== exp_time)   begin n_err++; $display("FAIL long time_bcd got %h want %h", time_bcd, exp_time); end
    n_vec++; if (date_bcd !== exp_date)   begin n_err++; $display("FAIL long date_bcd got %h want %h", date_bcd, exp_date); end
    n_vec++; if (fix_active !== 1'b1)     begin n_err++; $display("FAIL long fix_active got %b want 1", fix_active); end
  endtask

  task automatic test_gga();
    begin_epoch();
    send_sentence("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,", 1'b0);
    n_vec++; if (wr_tot - wr_b != 0)     begin n_err++; $display("FAIL gga write count got %0d want 0", wr_tot - wr_b); end
    n_vec++; if (busy_tot - busy_b != 0) begin n_err++; $display("FAIL gga busy cycles got %0d want 0", busy_tot - busy_b); end
    n_vec++; if (fd_tot - fd_b != 0)     begin n_err++; $display("FAIL gga frame_done pulses got %0d want 0", fd_tot - fd_b); end
    n_vec++; if (time_bcd !== exp_time)  begin n_err++; $display("FAIL gga time_bcd got %h want %h", time_bcd, exp_time); end
  endtask

  task automatic test_abort();
    begin_epoch();
    send_raw("$GPRMC,111111,A");
    send_sentence(rmc("202122", "A", "311298"), 1'b0);
    n_vec++; if (fd_tot - fd_b != 1)        begin n_err++; $display("FAIL abort frame_done pulses got %0d want 1", fd_tot - fd_b); end
    n_vec++; if (time_bcd !== 24'h202122)   begin n_err++; $display("FAIL abort time_bcd got %h want 202122", time_bcd); end
    n_vec++; if (date_bcd !== 24'h311298)   begin n_err++; $display("FAIL abort date_bcd got %h want 311298", date_bcd); end
  endtask

  task automatic test_reset_mid();
    send_raw("$GPRMC,12");
    @(negedge PixelClk);
    nRST = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rstmid busy got %b want 0", busy); end
    n_vec++; if (time_bcd !== 24'd0)    begin n_err++; $display("FAIL rstmid time_bcd got %h want 0", time_bcd); end
    n_vec++; if (date_bcd !== 24'd0)    begin n_err++; $display("FAIL rstmid date_bcd got %h want 0", date_bcd); end
    n_vec++; if (time_valid !== 1'b0)   begin n_err++; $display("FAIL rstmid time_valid got %b want 0", time_valid); end
    n_vec++; if (fix_active !== 1'b0)   begin n_err++; $display("FAIL rstmid fix_active got %b want 0", fix_active); end
    n_vec++; if (ram_waddr !== 10'd0)   begin n_err++; $display("FAIL rstmid ram_waddr got %h want 0", ram_waddr); end
    n_vec++; if (ram_wdata !== 8'd0)    begin n_err++; $display("FAIL rstmid ram_wdata got %h want 0", ram_wdata); end
    repeat (2) @(negedge PixelClk);
    nRST = 1'b1;
    repeat (2) @(negedge PixelClk);
    begin_epoch();
    send_sentence(rmc("235959", "A", "311299"), 1'b0);
    n_vec++; if (time_bcd !== 24'h235959) begin n_err++; $display("FAIL rstmid time_bcd after got %h want 235959", time_bcd); end
    n_vec++; if (date_bcd !== 24'h311299) begin n_err++; $display("FAIL rstmid date_bcd after got %h want 311299", date_bcd); end
    n_vec++; if (time_valid !== 1'b1)     begin n_err++; $display("FAIL rstmid time_valid after got %b want 1", time_valid); end
    n_vec++; if (fix_active !== 1'b1)     begin n_err++; $display("FAIL rstmid fix_active after got %b want 1", fix_active); end
    n_vec++; if (fd_tot - fd_b != 1)      begin n_err++; $display("FAIL rstmid frame_done pulses got %0d want 1", fd_tot - fd_b); end
    check_row("rstmid time row", 0, "235959");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'd0;
      wep[i] = -1;
    end
    exp_time = 24'd0;
    exp_date = 24'd0;
    test_reset();
    test_rmc_basic();
    test_bad_cksum();
    test_void_bad_time();
    test_long_field();
    test_gga();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nmea_rmc_ctrl.md
# nmea_rmc_ctrl

Sequencer between the UART receiver and the dual-port text RAM of the LCD trip computer. Consumes received bytes, locates `$xxRMC` sentences, and streams each comma-separated field into its own 32-character RAM row. Extracts time and date digits into shadow registers and commits them to the display/clock logic only at a valid end of sentence. Optionally checks the NMEA checksum. Owns the RAM write port; the renderer owns the read port.

## Interface
Parameters:
- `ADDR_W`, 10: text RAM address width.
- `ROW_SHIFT`, 5: log2 of characters per row (32).
- `MAX_FIELDS`, 13: highest field index written; later fields are parsed but not stored.
- `TIME_FIELD`, 1: field index holding hhmmss.
- `STATUS_FIELD`, 2: field index holding the A/V fix flag.
- `DATE_FIELD`, 9: field index holding ddmmyy.

Ports (one clock; reset is asynchronous and active-low):
- `PixelClk` in 1: clock, 9 MHz LCD pixel clock.
- `nRST` in 1: asynchronous active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `ram_waddr` out ADDR_W: text RAM write address.
- `ram_wdata` out 8: text RAM write data.
- `ram_we` out 1: text RAM write enable, one cycle per stored byte.
- `time_bcd` out 24: committed hh,mm,ss; 4 bits per digit, MSB = tens of hours.
- `date_bcd` out 24: committed dd,mm,yy BCD.
- `time_valid` out 1: sticky; set at the first commit with a full 6-digit time.
- `fix_active` out 1: last committed status field was `A`.
- `busy` out 1: high while inside a sentence (FIELD or CKSUM state).
- `frame_done` out 1: one-cycle pulse on commit.
- `cksum_err` out 1: one-cycle pulse on checksum mismatch.

## Operation
States: HUNT, FIELD, CKSUM.
- HUNT:
  - Keep a 3-byte history of received bytes.
  - `$` resets the running XOR.
  - `,` with history == `RMC` → FIELD; field index = 1; column = 0; shadow registers cleared.
- FIELD, on each rx byte:
  - `*` → CKSUM if enabled, else commit → HUNT.
  - `$` → abort → HUNT, no commit.
  - `,` → field index++ (saturate at MAX_FIELDS+1); column = 0.
  - Other byte, when field ≤ MAX_FIELDS and column < 2^ROW_SHIFT: write at `((field-1) << ROW_SHIFT) | column`, then column++. Bytes past column 31 are dropped, with no wrap into the next row.
- Digit capture:
  - In TIME_FIELD/DATE_FIELD, the first 6 bytes go to shadow digit slots 0..5 as `byte - "0"` (low 4 bits).
  - Any non-`0`..`9` byte in slots 0..5 clears that group's shadow-ok flag. Fewer than 6 digits also leaves the flag clear.
  - STATUS_FIELD: first byte == `A` sets shadow fix.
- Commit:
  - `time_bcd` updates and `time_valid` sets only if the time shadow is ok.
  - `date_bcd` updates only if the date shadow is ok.
  - `fix_active` takes the shadow fix.
  - `frame_done` pulses.
- Running XOR covers every byte strictly between `$` and `*`.

## Timing
- All outputs are registered.
- Reset value of every output: 0, including `ram_waddr`, `ram_wdata`, the BCD buses, and all flags.
- `ram_we`/`ram_waddr`/`ram_wdata` assert exactly 1 cycle after the `rx_valid` that carried the byte, for 1 cycle.
- `frame_done`/`cksum_err` pulse 1 cycle after the terminating byte's `rx_valid`. Committed outputs change on that same edge.
- `busy` rises 1 cycle after the `,` that enters FIELD and falls 1 cycle after the terminating byte.
- No backpressure. `rx_valid` is separated by ≥1 idle cycle, and the block accepts one byte per cycle regardless.
- `nRST` mid-sentence: immediately returns to HUNT with no write and no commit. Outputs return to reset values.

## Configuration
- `NMEA_CKSUM_EN` defined:
  - CKSUM state consumes two hex chars, upper or lower case.
  - Match → commit. Mismatch or non-hex char → `cksum_err`, no commit.
  - Either way, return to HUNT after the second char or the bad char.
- Undefined: `*` commits directly, `cksum_err` is tied 0, and no XOR logic is built.

## Structure
- Package `nmea_pkg`:
  - state enum (HUNT, FIELD, CKSUM);
  - character constants (`$`, `,`, `*`, `A`, `R`, `M`, `C`);
  - default field indices;
  - a `hex2nib` function.
- Sub-module `nmea_cksum`: running XOR, hex-pair decode, and match/error flags. Instantiated only under `NMEA_CKSUM_EN`.

## Test plan
- Feed `$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A`:
  - `time_bcd`=24'h123519, `date_bcd`=24'h230394, `fix_active`=1, `time_valid`=1, one `frame_done`.
  - RAM writes `123519` at 0–5, `A` at 32, `230394` at 256–261.
- Same sentence ending `*6B` with `NMEA_CKSUM_EN`: `cksum_err` pulse, outputs unchanged, but RAM writes still occur.
- `V` status and time field `12a519`: `fix_active`=0, `time_bcd` holds previous value, `date_bcd` updates.
- 40-char field 3: only columns 0–31 of row 2 are written, and field 4 starts at address 96.
- `$GPGGA,…` sentence: no RAM writes, `busy` stays 0.
- `nRST` low after `$GPRMC,12`, then a full valid sentence: all outputs 0 during reset, then normal commit.
